// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encoding, frame-format constants and the
// baud divider helper. The receive path imports the same package.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_t;

  localparam int   UART_DEF_PAYLOAD_BITS = 8;
  localparam int   UART_DEF_STOP_BITS    = 1;
  localparam logic UART_LINE_IDLE        = 1'b1;
  localparam logic UART_START_LEVEL      = 1'b0;
  localparam logic UART_STOP_LEVEL       = 1'b1;

  // Clock cycles per line bit; integer truncation is intentional.
  function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO for the UART transmit path. Full/empty come from the level
// counter, so the pointers simply wrap.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic [WIDTH-1:0]       i_data,
  output logic [WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_level == FULL_LEVEL);
  assign o_empty   = (r_level == '0);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage carries no reset; only the pointers and level define validity.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes enter a FIFO over valid/ready and are
// serialised LSB first onto a registered, idle-high line.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int CLK_HZ       = 50000000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = UART_DEF_PAYLOAD_BITS,
  parameter int STOP_BITS    = UART_DEF_STOP_BITS,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PAYLOAD_BITS-1:0]     tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        uart_txd,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [1:0]                  o_dbg_state
);

  localparam int CPB   = cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int IDX_W = $clog2(PAYLOAD_BITS + 1);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CPB - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(PAYLOAD_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  uart_state_t             r_state;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic [IDX_W-1:0]        r_bit_idx;
  logic [PAYLOAD_BITS-1:0] r_shift;
  logic                    r_txd;
  logic                    r_busy;

  logic                    w_push;
  logic                    w_pop;
  logic                    w_full;
  logic                    w_empty;
  logic                    w_bit_done;
  logic                    w_last_stop;
  logic [PAYLOAD_BITS-1:0] w_head;
  logic [LVL_W-1:0]        w_level;

  // Handshake: a byte transfers on a rising edge where tx_valid && tx_ready;
  // tx_ready is purely !full, so a same-cycle pop never admits a push.
  assign w_push      = tx_valid && !w_full;
  assign w_bit_done  = (r_bit_cnt == CNT_LAST);
  assign w_last_stop = (r_state == ST_STOP) && w_bit_done && (r_bit_idx == STOP_LAST);
  assign w_pop       = !w_empty && ((r_state == ST_IDLE) || w_last_stop);

  uart_tx_fifo #(
    .WIDTH (PAYLOAD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (tx_data),
    .o_data  (w_head),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // The line register follows the state one cycle later, so every bit keeps
  // its full CPB-cycle width, including across a STOP->START handover.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txd     <= UART_LINE_IDLE;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_txd <= UART_LINE_IDLE;
          if (w_pop) begin
            r_shift   <= w_head;
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_state   <= ST_START;
          end
        end
        ST_START: begin
          r_txd <= UART_START_LEVEL;
          if (w_bit_done) begin
            r_bit_cnt <= '0;
            r_state   <= ST_DATA;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        ST_DATA: begin
          r_txd <= r_shift[0];
          if (w_bit_done) begin
            r_bit_cnt <= '0;
            r_shift   <= r_shift >> 1;
            if (r_bit_idx == DATA_LAST) begin
              r_bit_idx <= '0;
              r_state   <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        ST_STOP: begin
          r_txd <= UART_STOP_LEVEL;
          if (w_bit_done) begin
            r_bit_cnt <= '0;
            if (r_bit_idx == STOP_LAST) begin
              r_bit_idx <= '0;
              if (w_pop) begin
                r_shift <= w_head;
                r_state <= ST_START;
              end else begin
                r_state <= ST_IDLE;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      r_busy <= (r_state != ST_IDLE) || (w_level != '0);
    end
  end

  assign tx_ready    = !w_full;
  assign uart_txd    = r_txd;
  assign tx_busy     = r_busy;
  assign fifo_level  = w_level;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at 10 cycles per bit: scoreboard of pushed
// bytes checked by a line monitor, plus timing, backpressure and reset steps.
module tb_uart_tx_buffered;

  localparam int CPB   = 10;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       ready1, txd1, busy1;
  logic [2:0] level1;
  logic [1:0] dbg1;
  logic [7:0] tx_data2 = '0;
  logic       tx_valid2 = 1'b0;
  logic       ready2, txd2, busy2;
  logic [2:0] level2;
  logic [1:0] dbg2;

  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         frame_starts[$];
  logic       mon_en = 1'b0;

  uart_tx_buffered #(
    .CLK_HZ(1000000), .BIT_RATE(100000), .PAYLOAD_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(ready1),
    .uart_txd(txd1), .tx_busy(busy1), .fifo_level(level1), .o_dbg_state(dbg1)
  );

  uart_tx_buffered #(
    .CLK_HZ(1000000), .BIT_RATE(100000), .PAYLOAD_BITS(8), .STOP_BITS(2), .FIFO_DEPTH(4)
  ) u_dut2 (
    .clk(clk), .reset(reset), .tx_data(tx_data2), .tx_valid(tx_valid2), .tx_ready(ready2),
    .uart_txd(txd2), .tx_busy(busy2), .fifo_level(level2), .o_dbg_state(dbg2)
  );

  // Clock and edge counter: at each falling edge, cyc equals the number of rising edges so far.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; holds tx_valid until the byte transfers and returns
  // at the falling edge after the transfer edge with tx_valid still high.
  task automatic send(input logic [7:0] b, output int edge_n);
    logic ok;
    ok = 1'b0;
    edge_n = -1;
    tx_valid = 1'b1;
    tx_data = b;
    for (int i = 0; i < 400; i++) begin
      if (ready1 === 1'b1) begin
        edge_n = cyc + 1;
        @(negedge clk);
        exp_q.push_back(b);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("send_accepted", ok, 1'b1);
  endtask

  // Line monitor: mid-bit sampling of each frame, compared against the scoreboard.
  int         mon_st;
  int         mon_qn;
  logic [9:0] mon_f;
  logic [7:0] mon_exp;
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && !reset && txd1 === 1'b0) begin
        mon_st = cyc;
        repeat (CPB / 2) @(negedge clk);
        mon_f[0] = txd1;
        for (int k = 1; k < 10; k++) begin
          repeat (CPB) @(negedge clk);
          mon_f[k] = txd1;
        end
        frame_starts.push_back(mon_st);
        check("mon_start_bit", mon_f[0], 1'b0);
        check("mon_stop_bit", mon_f[9], 1'b1);
        mon_qn = exp_q.size();
        check("mon_queue_nonempty", mon_qn != 0, 1'b1);
        if (mon_qn != 0) begin
          mon_exp = exp_q.pop_front();
          check("mon_data", mon_f[8:1], mon_exp);
        end
      end
    end
  end

  initial begin
    int p, p_a1, p_5a, p_c3, fall, bad;
    logic b_last, b_after, t_after, ok;
    logic [9:0] fr;

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_txd", txd1, 1'b1);
    check("rst_ready", ready1, 1'b1);
    check("rst_busy", busy1, 1'b0);
    check("rst_level", level1, 3'd0);
    check("rst_state", dbg1, 2'd0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 3 * CPB; i++) begin
      @(negedge clk);
      if (txd1 !== 1'b1 || busy1 !== 1'b0 || ready1 !== 1'b1 || level1 !== 3'd0) bad++;
    end
    check("idle_bad_cycles", bad, 0);

    // Single 0x55 frame: latency, exact bit widths, busy drop
    mon_en = 1'b1;
    send(8'h55, p);
    tx_valid = 1'b0;
    fall = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (txd1 === 1'b0) begin fall = cyc; break; end
    end
    check("t55_fall_latency", fall - p, 2);
    fr = {1'b1, 8'h55, 1'b0};
    bad = 0;
    b_last = 1'b0; b_after = 1'b1; t_after = 1'b0;
    for (int o = 0; o <= FRAME; o++) begin
      if (o < FRAME && txd1 !== fr[o / CPB]) bad++;
      if (o == FRAME - 1) b_last = busy1;
      if (o == FRAME) begin b_after = busy1; t_after = txd1; end
      if (o < FRAME) @(negedge clk);
    end
    check("t55_line_shape_bad", bad, 0);
    check("t55_busy_last_stop", b_last, 1'b1);
    check("t55_busy_after", b_after, 1'b0);
    check("t55_txd_after", t_after, 1'b1);
    check("t55_drained", exp_q.size(), 0);

    // Back-to-back with tx_valid held, then a push held off while full
    frame_starts.delete();
    send(8'hA1, p_a1);
    check("b2b_level_a1", level1, 3'd1);
    send(8'h34, p);
    check("b2b_level_34", level1, 3'd1);
    send(8'hAB, p);
    check("b2b_level_ab", level1, 3'd2);
    send(8'hCD, p);
    check("b2b_level_cd", level1, 3'd3);
    send(8'hEF, p);
    check("b2b_level_ef", level1, 3'd4);
    check("b2b_ready_full", ready1, 1'b0);
    tx_data = 8'h5A;
    bad = 0;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (ready1 === 1'b1) begin ok = 1'b1; break; end
      if (level1 !== 3'd4) bad++;
      @(negedge clk);
    end
    check("full_wait_ready", ok, 1'b1);
    check("full_level_held", bad, 0);
    check("full_pop_level", level1, 3'd3);
    p_5a = cyc + 1;
    check("full_accept_edge", p_5a - p_a1, FRAME + 2);
    @(negedge clk);
    exp_q.push_back(8'h5A);
    tx_valid = 1'b0;
    check("full_refill_level", level1, 3'd4);
    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
    check("b2b_drained", exp_q.size(), 0);
    for (int i = 0; i < 200 && busy1 !== 1'b0; i++) @(negedge clk);
    check("b2b_busy_clear", busy1, 1'b0);
    check("b2b_frame_count", frame_starts.size(), 6);
    if (frame_starts.size() != 0) check("b2b_first_latency", frame_starts[0] - p_a1, 2);
    for (int k = 1; k < frame_starts.size(); k++)
      check("b2b_gap", frame_starts[k] - frame_starts[k-1], FRAME);

    // Reset in DATA bit 3 of 0xC3 with two bytes queued
    mon_en = 1'b0;
    send(8'hC3, p_c3);
    send(8'h11, p);
    send(8'h22, p);
    tx_valid = 1'b0;
    while (cyc < p_c3 + 2 + 4 * CPB + CPB / 2) @(negedge clk);
    check("rst_mid_pre_line", txd1, 1'b0);
    check("rst_mid_pre_level", level1, 3'd2);
    reset = 1'b1;
    #1;
    check("rst_mid_txd", txd1, 1'b1);
    check("rst_mid_level", level1, 3'd0);
    check("rst_mid_busy", busy1, 1'b0);
    check("rst_mid_ready", ready1, 1'b1);
    check("rst_mid_state", dbg1, 2'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    bad = 0;
    for (int i = 0; i < 2 * CPB; i++) begin
      @(negedge clk);
      if (txd1 !== 1'b1 || busy1 !== 1'b0 || level1 !== 3'd0) bad++;
    end
    check("rst_post_quiet_bad", bad, 0);

    // Two stop bits: 0xFF frame is 110 cycles, low only for the start bit
    tx_valid2 = 1'b1;
    tx_data2 = 8'hFF;
    check("sb2_ready", ready2, 1'b1);
    @(negedge clk);
    p = cyc;
    tx_valid2 = 1'b0;
    fall = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (txd2 === 1'b0) begin fall = cyc; break; end
    end
    check("sb2_fall_latency", fall - p, 2);
    bad = 0;
    b_last = 1'b0; b_after = 1'b1; t_after = 1'b0;
    for (int o = 0; o <= 11 * CPB; o++) begin
      if (o < 11 * CPB && txd2 !== ((o < CPB) ? 1'b0 : 1'b1)) bad++;
      if (o == 11 * CPB - 1) b_last = busy2;
      if (o == 11 * CPB) begin b_after = busy2; t_after = txd2; end
      if (o < 11 * CPB) @(negedge clk);
    end
    check("sb2_line_shape_bad", bad, 0);
    check("sb2_busy_last_stop", b_last, 1'b1);
    check("sb2_busy_after", b_after, 1'b0);
    check("sb2_txd_after", t_after, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
